// File: rtl/serdes_pkg.sv
// rtl/serdes_pkg.sv - shared state encoding and counter sizing for the serdes path
package serdes_pkg;

   typedef enum logic {
      SER_IDLE = 1'b0,
      SER_BUSY = 1'b1
   } ser_state_e;

   // max(1, clog2(n)) so a single-word frame still gets a real counter bit
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/serdes_serializer_ctrl.sv
// rtl/serdes_serializer_ctrl.sv - serializer FSM and word counter
// SERDES_SERIALIZER_OVERLAP_EN: accept the next frame on the last-word handshake
module serdes_serializer_ctrl
   import serdes_pkg::*;
#(
   parameter int N_SAMPLES = 8,
   parameter int CW        = cnt_width(N_SAMPLES)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          recv_val,
   output logic          recv_rdy,
   output logic          send_val,
   input  logic          send_rdy,
   output logic [CW-1:0] count,
   output logic          load_en
);

   localparam logic [CW-1:0] LAST = CW'(N_SAMPLES - 1);

   ser_state_e    state;
   ser_state_e    state_nxt;
   logic [CW-1:0] count_nxt;
   logic          last;

   assign last = (count == LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= SER_IDLE;
         count <= '0;
      end else begin
         state <= state_nxt;
         count <= count_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      count_nxt = count;
      recv_rdy  = 1'b0;
      send_val  = 1'b0;
      load_en   = 1'b0;
      case (state)
         SER_IDLE: begin
            recv_rdy = 1'b1;
            if (recv_val) begin
               load_en   = 1'b1;
               count_nxt = '0;
               state_nxt = SER_BUSY;
            end
         end
         SER_BUSY: begin
            send_val = 1'b1;
`ifdef SERDES_SERIALIZER_OVERLAP_EN
            if (last) begin
               recv_rdy = send_rdy;
            end
`endif
            if (send_rdy) begin
               if (last) begin
                  count_nxt = '0;
`ifdef SERDES_SERIALIZER_OVERLAP_EN
                  if (recv_val) begin
                     load_en = 1'b1;
                  end else begin
                     state_nxt = SER_IDLE;
                  end
`else
                  state_nxt = SER_IDLE;
`endif
               end else begin
                  count_nxt = count + 1'b1;
               end
            end
         end
      endcase
   end

endmodule

// File: rtl/serdes_serializer.sv
// rtl/serdes_serializer.sv - registers a parallel frame and streams it out word by word
// SERDES_SERIALIZER_OVERLAP_EN: back-to-back frames without an idle cycle
module serdes_serializer
   import serdes_pkg::*;
#(
   parameter int N_SAMPLES = 8,
   parameter int BIT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 recv_val,
   output logic                 recv_rdy,
   input  logic [BIT_WIDTH-1:0] recv_msg [N_SAMPLES-1:0],
   output logic                 send_val,
   input  logic                 send_rdy,
   output logic [BIT_WIDTH-1:0] send_msg
);

   localparam int CW = cnt_width(N_SAMPLES);

   logic [CW-1:0]        count;
   logic                 load_en;
   logic [BIT_WIDTH-1:0] frame_q [N_SAMPLES-1:0];

   serdes_serializer_ctrl #(
      .N_SAMPLES (N_SAMPLES),
      .CW        (CW)
   ) u_ctrl (
      .clk      (clk),
      .reset    (reset),
      .recv_val (recv_val),
      .recv_rdy (recv_rdy),
      .send_val (send_val),
      .send_rdy (send_rdy),
      .count    (count),
      .load_en  (load_en)
   );

   // buffer only changes on a frame capture; count rests at 0 so IDLE shows word 0
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < N_SAMPLES; i++) begin
            frame_q[i] <= '0;
         end
      end else if (load_en) begin
         for (int i = 0; i < N_SAMPLES; i++) begin
            frame_q[i] <= recv_msg[i];
         end
      end
   end

   assign send_msg = frame_q[count];

endmodule

// File: doc/serdes_serializer.md
Name: serdes_serializer

Overview:
Parallel-to-serial stage that sits directly downstream of the deserializer in the serdes path.
- Accepts one frame of N_SAMPLES words in a single val/rdy handshake.
- Registers the whole frame.
- Streams the words out one per handshake, index 0 first, on a val/rdy output port.
- Used to return processed sample frames (e.g. FFT output) to a word-serial interface.

Parameters:
- N_SAMPLES, 8, words per frame; must be >= 1.
- BIT_WIDTH, 32, width of each word.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- reset  input  1  reset, asynchronous and active-low; asserting it low immediately clears all state.
- recv_val  input  1  frame valid.
- recv_rdy  output  1  frame ready.
- recv_msg  input  BIT_WIDTH x N_SAMPLES (unpacked array [N_SAMPLES-1:0])  frame words; element i is output in position i.
- send_val  output  1  word valid.
- send_rdy  input  1  word ready.
- send_msg  output  BIT_WIDTH  current word.

Behaviour:
- Handshake: a transfer occurs on a rising edge where val & rdy are both 1. rdy/val may not combinationally depend on the partner's val/rdy, except as described under Optional Feature.
- State IDLE (reset state):
  - recv_rdy=1, send_val=0.
  - On recv_val: capture all N_SAMPLES words into the frame buffer, set count=0, go to BUSY.
- State BUSY:
  - recv_rdy=0, send_val=1, send_msg=buf[count].
  - On send_rdy with count < N_SAMPLES-1: count <= count+1.
  - On send_rdy with count == N_SAMPLES-1: count <= 0, go to IDLE.
  - Without send_rdy: hold count and send_msg stable (no word dropped or repeated).
- Counter width: max(1, $clog2(N_SAMPLES)). Compare against N_SAMPLES-1 only, so the counter never wraps past the final index.
- Latency: the first word is valid on the cycle after frame capture. Throughput is N_SAMPLES+1 cycles per frame with send_rdy held high; the extra cycle is the IDLE capture cycle.
- N_SAMPLES==1: same FSM. Each frame costs 2 cycles and count stays 0.
- Reset values:
  - state=IDLE, count=0.
  - Buffer all zeros.
  - recv_rdy=1, send_val=0, send_msg=0 (send_msg is buf[0] while IDLE).
- Reset mid-frame: unsent words are discarded, the block is in IDLE on the first clock after deassertion, and no stale word is emitted afterwards.
- recv_msg is ignored whenever the recv handshake does not fire; the buffer changes only on capture.
- send_rdy is ignored while IDLE.

Optional Feature:
- Macro: SERDES_SERIALIZER_OVERLAP_EN.
- Defined:
  - In BUSY with count==N_SAMPLES-1, recv_rdy = send_rdy (combinational).
  - If recv_val is also 1 on that edge, the new frame is captured, count=0 and the block stays in BUSY. Streams are back-to-back with no bubble: N_SAMPLES cycles per frame.
  - If recv_val=0, go to IDLE as normal.
- Undefined: behaviour exactly as above, recv_rdy is purely a function of state, and there is one idle cycle between frames.

Decomposition:
- Package serdes_pkg:
  - state enum (SER_IDLE, SER_BUSY), 1-bit encoded.
  - Function cnt_width(n) = max(1, $clog2(n)), shared with the deserializer.
- Sub-module serdes_serializer_ctrl: FSM plus counter, driving recv_rdy, send_val, count and buffer load-enable.
- The datapath stays in the top level: N cmn_EnResetReg-style buffer registers with an async-low reset variant, plus the output mux indexed by count.

Test Plan:
- Reset, then frame {0x10,0x11,...,0x17} with send_rdy=1 -> recv_rdy falls the next cycle; send_msg = 0x10..0x17 on 8 consecutive cycles; back to IDLE with recv_rdy=1 on cycle 9.
- Backpressure: send_rdy toggling 1,0,0,1,... -> each word is held stable while send_rdy=0, the sequence is unchanged, and exactly 8 send transfers occur.
- Frame input changes while BUSY: recv_val=1 with a different recv_msg -> ignored, recv_rdy=0, and the output still shows the original frame.
- Reset pulled low after 3 words are sent -> send_val=0 immediately; after release, IDLE with recv_rdy=1; a new frame {0xA0..0xA7} outputs starting at 0xA0.
- N_SAMPLES=1 build: frame {0x5} -> send_val the next cycle with send_msg=0x5; IDLE after the handshake; 2 cycles per frame under continuous traffic.
- SERDES_SERIALIZER_OVERLAP_EN with continuous recv_val and send_rdy -> 16 words from two frames on 16 consecutive cycles with no send_val gap. Without the macro, there is exactly one gap cycle.
